// File: rtl/accum_pkg.sv
// Shared types and default geometry for the accumulator drain sequencer.
package accum_pkg;

  localparam int unsigned ACC_NUM_BANKS  = 4;
  localparam int unsigned ACC_ADDR_WIDTH = 9;
  localparam int unsigned ACC_DATA_WIDTH = 64;
  localparam int unsigned ACC_FIFO_DEPTH = 4;

  // Length field must represent a full sweep of 2^addr_width rows.
  function automatic int unsigned len_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  localparam int unsigned ACC_LEN_WIDTH = len_width(ACC_ADDR_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } drain_state_e;

  typedef struct packed {
    logic [ACC_NUM_BANKS*ACC_DATA_WIDTH-1:0] data;
    logic                                    last;
  } row_entry_t;

endpackage

// File: rtl/accum_drain_fifo.sv
// Synchronous FIFO with registered storage and occupancy count; any depth >= 1.
module accum_drain_fifo #(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(push_i && full && !pop_i));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
    !(pop_i && (count_q == '0)));

endmodule

// File: rtl/accum_drain_ctrl.sv
// Drains a row range of the accumulator banks to a ready/valid stream,
// optionally zeroing each row behind the read.
module accum_drain_ctrl
  import accum_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = ACC_NUM_BANKS,
  parameter int unsigned ADDR_WIDTH = ACC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = ACC_FIFO_DEPTH,
  parameter int unsigned LEN_WIDTH  = len_width(ADDR_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [LEN_WIDTH-1:0]            len,
  input  logic [NUM_BANKS-1:0]            bank_mask,
  input  logic                            clear_en,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [NUM_BANKS-1:0]            rd_mask,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [NUM_BANKS-1:0]            wr_mask,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  output logic                            accum_en,
  input  logic                            rvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
  output logic                            out_last
);

  localparam int unsigned ROW_W = NUM_BANKS * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  drain_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [LEN_WIDTH-1:0]  rx_left_q, rx_left_d;
  logic [NUM_BANKS-1:0]  mask_q, mask_d;
  logic                  clr_en_q, clr_en_d;
  logic [1:0]            inflight_q, inflight_d;
  logic                  clr_pend_q, clr_pend_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  logic [CNT_W-1:0]      fifo_count;
  logic [ROW_W:0]        fifo_head;
  logic [ROW_W-1:0]      rdata_masked;
  logic                  credit_ok;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  accept;
  logic                  pop;
  logic                  drained;

  // The read return cannot be stalled, so every row in flight must already
  // own a FIFO slot before its read command is issued.
  assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
  assign wr_fire   = clr_pend_q && wr_ready && wready;
  assign rd_valid  = (state_q == RUN) && credit_ok && !(clr_pend_q && !wr_fire);
  assign rd_fire   = rd_valid && rd_ready;
  assign accept    = rvalid && (state_q != IDLE) && (inflight_q != 2'd0);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  assign drained = (inflight_q == 2'd0) &&
                   ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)) &&
                   (!clr_pend_q || wr_fire);

  always_comb begin
    rdata_masked = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      rdata_masked[b*DATA_WIDTH +: DATA_WIDTH] =
        mask_q[b] ? rdata[b*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    rx_left_d  = rx_left_q;
    mask_d     = mask_q;
    clr_en_d   = clr_en_q;
    clr_pend_d = clr_pend_q;
    clr_addr_d = clr_addr_q;
    inflight_d = inflight_q + 2'(rd_fire) - 2'(accept);

    if (accept) begin
      rx_left_d = rx_left_q - LEN_WIDTH'(1);
    end

    if (rd_fire && clr_en_q) begin
      clr_pend_d = 1'b1;
      clr_addr_d = addr_q;
    end else if (wr_fire) begin
      clr_pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          remain_d  = len;
          rx_left_d = len;
          mask_d    = bank_mask;
          clr_en_d  = clear_en;
          state_d   = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_fire) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (drained) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      rx_left_q  <= '0;
      mask_q     <= '0;
      clr_en_q   <= 1'b0;
      inflight_q <= '0;
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      rx_left_q  <= rx_left_d;
      mask_q     <= mask_d;
      clr_en_q   <= clr_en_d;
      inflight_q <= inflight_d;
      clr_pend_q <= clr_pend_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  accum_drain_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (accept),
    .push_data_i ({rdata_masked, (rx_left_q == LEN_WIDTH'(1))}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_addr  = addr_q;
  assign rd_mask  = mask_q;
  assign wr_valid = clr_pend_q;
  assign wvalid   = clr_pend_q;
  assign wr_addr  = clr_addr_q;
  assign wr_mask  = mask_q;
  assign wdata    = '0;
  assign accum_en = 1'b0;
  assign out_data = fifo_head[ROW_W:1];
  assign out_last = fifo_head[0];

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// Scoreboard bench: accumulator slave model with 2-cycle read latency plus
// expected-read, expected-write and expected-output queues.
`timescale 1ns/1ps
module tb_accum_drain_ctrl;
  import accum_pkg::*;

  localparam int unsigned NB   = 4;
  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 64;
  localparam int unsigned FD   = 4;
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned BW   = NB * DW;
  localparam int unsigned ROWS = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start, clear_en, rd_ready, wr_ready, wready, out_ready;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic [NB-1:0] bank_mask;
  logic          busy, done, rd_valid, wr_valid, wvalid, accum_en;
  logic          out_valid, out_last;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [NB-1:0] rd_mask, wr_mask;
  logic [BW-1:0] wdata, out_data;
  logic          rvalid = 1'b0;
  logic [BW-1:0] rdata  = '0;

  always #5 clk = ~clk;

  accum_drain_ctrl #(
    .NUM_BANKS  (NB),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .bank_mask(bank_mask), .clear_en(clear_en), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_mask(rd_mask),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .accum_en(accum_en),
    .rvalid(rvalid), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  logic [DW-1:0] mem [ROWS][NB];
  logic [NB-1:0] cleared [ROWS];
  row_entry_t    exp_out[$];
  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wr[$];
  logic [NB-1:0] cur_mask = '0;
  logic          cur_clr = 1'b0;
  int unsigned   n_chk = 0, n_pass = 0;
  int unsigned   cyc = 0, t0 = 0, rd_cnt = 0, pop_cnt = 0;
  logic          p0_v = 1'b0, p1_v = 1'b0, rd_clr_prev = 1'b0;
  logic [BW-1:0] p0_d = '0, p1_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned r, input int unsigned b);
    return {16'hACC0, 16'(b), 32'(r) ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [BW-1:0] exp_row(input int unsigned r, input logic [NB-1:0] m);
    logic [BW-1:0] v;
    v = '0;
    for (int unsigned b = 0; b < NB; b++)
      if (m[b] && !cleared[r][b]) v[b*DW +: DW] = pat(r, b);
    return v;
  endfunction

  // Accumulator slave: captures reads mid-cycle, returns data two cycles later.
  always @(negedge clk) begin
    rvalid = p1_v;
    rdata  = p1_d;
    p1_v   = p0_v;
    p1_d   = p0_d;
    p0_v   = 1'b0;
    if (rd_clr_prev) check("wr_follows_rd", {wr_valid, wvalid}, 2'b11);
    rd_clr_prev = 1'b0;
    if (rd_valid && rd_ready) begin
      p0_v = 1'b1;
      for (int unsigned b = 0; b < NB; b++) p0_d[b*DW +: DW] = mem[rd_addr][b];
      rd_cnt++;
      check("rd_expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) check("rd_addr", rd_addr, exp_rd.pop_front());
      check("rd_mask", rd_mask, cur_mask);
      rd_clr_prev = cur_clr;
    end
    if (wr_valid && wvalid && wr_ready && wready) begin
      check("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) check("wr_addr", wr_addr, exp_wr.pop_front());
      check("wr_mask", wr_mask, cur_mask);
      check("wdata_zero", wdata, 0);
      for (int unsigned b = 0; b < NB; b++)
        if (wr_mask[b]) mem[wr_addr][b] = '0;
    end
  end

  always @(negedge clk) begin : monitor
    row_entry_t e;
    if (rstn && out_valid && out_ready) begin
      pop_cnt++;
      check("out_expected", exp_out.size() != 0, 1);
      if (exp_out.size() != 0) begin
        e = exp_out.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_job(input int unsigned base, input int unsigned n,
                           input logic [NB-1:0] m, input logic c);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned r;
      row_entry_t  e;
      r      = (base + i) % ROWS;
      e.data = exp_row(r, m);
      e.last = (i == n - 1);
      exp_out.push_back(e);
      exp_rd.push_back(AW'(r));
      if (c) exp_wr.push_back(AW'(r));
    end
    if (c) for (int unsigned i = 0; i < n; i++) cleared[(base + i) % ROWS] |= m;
    cur_mask  = m;
    cur_clr   = c;
    rd_cnt    = 0;
    start     = 1'b1;
    base_addr = AW'(base);
    len       = LW'(n);
    bank_mask = m;
    clear_en  = c;
    t0        = cyc;
    step();
    start = 1'b0;
    check("busy_T1", busy, 1);
    check("rd_valid_T1", rd_valid, n != 0);
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input int unsigned limit);
    while (!done && (cyc - t0) < limit) step();
    check({name, "_done_seen"}, done, 1);
    if (exp_cyc >= 0) check({name, "_done_cycle"}, cyc - t0, exp_cyc);
    step();
    check({name, "_done_pulse_idle"}, {done, busy}, 2'b00);
    check({name, "_queues_empty"}, exp_out.size() + exp_rd.size() + exp_wr.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {busy, done, rd_valid, wr_valid, wvalid, out_valid, out_last, accum_en}, 0);
    check({name, "_addr_mask"}, {rd_addr, wr_addr, rd_mask, wr_mask}, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_wdata"}, wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned p_base;
    start = 1'b0; base_addr = '0; len = '0; bank_mask = '0; clear_en = 1'b0;
    rd_ready = 1'b1; wr_ready = 1'b1; wready = 1'b1; out_ready = 1'b1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      cleared[r] = '0;
      for (int unsigned b = 0; b < NB; b++) mem[r][b] = pat(r, b);
    end
    repeat (3) step();
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    issue_job(32'h010, 4, 4'b1111, 1'b0);
    wait_done("basic", 8, 50);

    issue_job(32'h1FE, 3, 4'b1111, 1'b1);
    wait_done("wrap_clear", 7, 50);
    issue_job(32'h1FE, 3, 4'b1111, 1'b0);
    wait_done("wrap_redrain", 7, 50);

    issue_job(32'h040, 2, 4'b0101, 1'b1);
    wait_done("mask_clear", 6, 50);
    issue_job(32'h040, 2, 4'b1111, 1'b0);
    wait_done("mask_redrain", 6, 50);

    out_ready = 1'b0;
    issue_job(32'h080, 8, 4'b1111, 1'b0);
    repeat (4) step();
    start = 1'b1; len = LW'(1); base_addr = AW'(32'h100);
    step();
    start = 1'b0;
    repeat (5) step();
    check("bp_reads_credit", rd_cnt, FD);
    check("bp_out_held", {out_valid, busy}, 2'b11);
    out_ready = 1'b1;
    wait_done("backpressure", -1, 100);
    check("bp_reads_total", rd_cnt, 8);

    issue_job(32'h050, 0, 4'b1111, 1'b0);
    wait_done("len0", 1, 10);
    check("len0_reads", rd_cnt, 0);

    p_base = pop_cnt;
    issue_job(32'h0C0, 8, 4'b1111, 1'b0);
    for (int k = 0; k < 50 && (pop_cnt - p_base) < 3; k++) step();
    check("rst_reached_row3", (pop_cnt - p_base) >= 3, 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    exp_out.delete();
    exp_rd.delete();
    exp_wr.delete();
    step();
    rstn = 1'b1;
    repeat (4) step();
    check("post_reset_idle", {busy, out_valid}, 2'b00);
    issue_job(32'h0C8, 8, 4'b1111, 1'b0);
    wait_done("after_reset", 12, 50);

    issue_job(32'h123, ROWS, 4'b1111, 1'b0);
    wait_done("full_sweep", ROWS + 4, ROWS + 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
